// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core, debug/DMA) arbiter in front of a single-ported
// data memory. The core has priority under contention. A starvation counter
// forces a debug grant after STARVE_LIMIT consecutive contended core wins.
// Read data returns one cycle after the grant, tagged to the owning port.
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // core port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  // debug / DMA port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory side
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       c_pend_q, c_pend_d;
  logic       d_pend_q, d_pend_d;
  logic       contend;
  logic       d_win;

  // Grant decision; gated by reset so grants drop asynchronously with it.
  always_comb begin
    contend = c_req & d_req;
    d_win   = contend & (starve_cnt_q == LIMIT);
    c_gnt   = reset & c_req & ~d_win;
    d_gnt   = reset & d_req & (~c_req | d_win);
  end

  // Memory strobe and address/data mux from the granted port; zeros when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (c_gnt) begin
      mem_en    = 1'b1;
      mem_we    = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Next state: starvation count and which port owns the next read return.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (d_gnt)
      starve_cnt_d = '0;
    else if (contend && c_gnt)
      starve_cnt_d = starve_cnt_q + 4'd1;
    c_pend_d = c_gnt & ~c_we;
    d_pend_d = d_gnt & ~d_we;
  end

  // State registers; reset also discards any read granted just before it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_q <= '0;
      c_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      c_pend_q     <= c_pend_d;
      d_pend_q     <= d_pend_d;
    end
  end

  // Read return steering; rdata is forced to zero when not valid.
  always_comb begin
    c_rvalid = c_pend_q;
    d_rvalid = d_pend_q;
    c_rdata  = c_pend_q ? mem_rdata : '0;
    d_rdata  = d_pend_q ? mem_rdata : '0;
    busy     = c_pend_q | d_pend_q;
  end

endmodule
